// File: rtl/seq_mult_unit.sv
// Multi-cycle WIDTH x WIDTH multiplier: radix-2 Booth for signed operands, shift-add for unsigned.
// One iteration per clock; start/ready/busy/done handshake toward the control FSM.
module seq_mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic             q1_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] out_hi_q;
  logic [WIDTH-1:0] out_lo_q;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   a_sum;
  logic [WIDTH:0]   a_d;
  logic [WIDTH-1:0] q_d;
  logic             q1_d;

  // One multiply iteration; A carries a guard bit so the add/subtract cannot overflow.
  always_comb begin
    m_ext = mode_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
    a_sum = a_q;
    a_d   = a_q;
    if (mode_q) begin
      case ({q_q[0], q1_q})
        2'b10:   a_sum = a_q - m_ext;
        2'b01:   a_sum = a_q + m_ext;
        default: a_sum = a_q;
      endcase
      a_d = {a_sum[WIDTH], a_sum[WIDTH:1]};
    end else begin
      if (q_q[0]) begin
        a_sum = a_q + m_ext;
      end
      a_d = {1'b0, a_sum[WIDTH:1]};
    end
    q_d  = {a_sum[0], q_q[WIDTH-1:1]};
    q1_d = q_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      q1_q     <= 1'b0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_hi_q <= '0;
      out_lo_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= in1;
            q_q     <= in0;
            a_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= is_signed;
            state_q <= S_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // The last iteration's result goes straight to the output registers.
          if (cnt_q == LAST_CNT) begin
            out_hi_q <= a_d[WIDTH-1:0];
            out_lo_q <= q_d;
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign out_hi = out_hi_q;
  assign out_lo = out_lo_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Scoreboarded random/directed bench for seq_mult_unit; expected products come from plain
// integer multiplication of the issued operands.
module tb_seq_mult_unit;

  localparam int W  = 32;
  localparam int CW = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] out_hi;
  logic [W-1:0] out_lo;

  seq_mult_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .in0       (in0),
    .in1       (in1),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .out_hi    (out_hi),
    .out_lo    (out_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    longint       acc;
    bit           b2b;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint last_done = -1;
  logic [W-1:0] min_v;
  logic [W-1:0] ones_v;
  logic [2*W-1:0] hold_p;

  always @(posedge clk) cyc++;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    logic [2*W-1:0] ua;
    logic [2*W-1:0] ub;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    return ua * ub;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: one-hot status every cycle; each done pulse pops one expected result.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("onehot", 128'($countones({ready, busy, done})), 128'd1);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("out_hi", 128'(out_hi), 128'(mon_e.hi));
          chk("out_lo", 128'(out_lo), 128'(mon_e.lo));
          // Start cycle through done cycle spans WIDTH+1 clocks.
          chk("latency", 128'(cyc - mon_e.acc), 128'(W));
          if (mon_e.b2b) chk("done_spacing", 128'(cyc - last_done), 128'(W + 2));
          $display("op done: hi=%h lo=%h cycle=%0d", out_hi, out_lo, cyc);
        end
        last_done = cyc;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit push, input bit b2b, input int gap);
    int t;
    exp_t e;
    logic [2*W-1:0] p;
    t = 0;
    while (ready !== 1'b1 && t < 4 * W) begin
      @(posedge clk); #1;
      t++;
    end
    if (ready !== 1'b1) begin
      fail_now("ready_timeout");
      return;
    end
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in0       = a;
    in1       = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    in0       = W'({$urandom, $urandom});
    in1       = W'({$urandom, $urandom});
    is_signed = ~s;
    if (push) begin
      p     = ref_mul(a, b, s);
      e.hi  = p[2*W-1:W];
      e.lo  = p[W-1:0];
      e.acc = cyc;
      e.b2b = b2b;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || ready !== 1'b1) && t < 8 * W) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb_q.size() != 0 || ready !== 1'b1) fail_now("idle_timeout");
  endtask

  function automatic logic [W-1:0] pick_operand();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       return ones_v;
      1:       return min_v;
      2:       return '0;
      default: return W'({$urandom, $urandom});
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int gap;
    min_v     = {1'b1, {(W-1){1'b0}}};
    ones_v    = '1;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    in0       = '0;
    in1       = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_ready", 128'(ready), 128'd1);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_hi", 128'(out_hi), 128'd0);
    chk("reset_lo", 128'(out_lo), 128'd0);

    // Directed corner products.
    issue(W'(7), W'(-3), 1'b1, 1'b1, 1'b0, 0);
    issue(ones_v, ones_v, 1'b0, 1'b1, 1'b1, 0);
    issue(ones_v, ones_v, 1'b1, 1'b1, 1'b1, 0);
    wait_idle();
    hold_p = ref_mul(ones_v, ones_v, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("hold_hi", 128'(out_hi), 128'(hold_p[2*W-1:W]));
    chk("hold_lo", 128'(out_lo), 128'(hold_p[W-1:0]));
    issue(min_v, min_v, 1'b1, 1'b1, 1'b0, 0);
    issue(min_v, ones_v, 1'b0, 1'b1, 1'b1, 0);
    wait_idle();

    // A second start with different operands while running must be ignored.
    issue(W'(12345), W'(-678), 1'b1, 1'b1, 1'b0, 0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("busy_in_run", 128'(busy), 128'd1);
    in0       = W'({$urandom, $urandom});
    in1       = W'({$urandom, $urandom});
    is_signed = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    wait_idle();
    repeat (W + 4) begin
      @(posedge clk); #1;
    end

    // Reset in the middle of a run aborts it without a done pulse.
    issue(min_v, min_v, 1'b1, 1'b0, 1'b0, 0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_ready", 128'(ready), 128'd1);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_hi", 128'(out_hi), 128'd0);
    chk("abort_lo", 128'(out_lo), 128'd0);
    repeat (W + 4) begin
      @(posedge clk); #1;
    end

    // Random traffic, mostly back-to-back.
    for (int i = 0; i < 1000; i++) begin
      a   = pick_operand();
      b   = pick_operand();
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      issue(a, b, 1'($urandom_range(0, 1)), 1'b1, (i > 0) && (gap == 0), gap);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
